// File: rtl/i281_pkg.sv
// Shared i281 constants: major opcodes, one-hot opcode bit indices, opcode
// bus layout and fetch state encoding. Also used by the control FSM.
package i281_pkg;

  // Opcode bus layout: [22:0] one-hot opcode, [24:23] RY, [26:25] RX
  localparam int OPBUS_W      = 27;
  localparam int OPBUS_OP_W   = 23;
  localparam int OPBUS_RY_LSB = 23;
  localparam int OPBUS_RX_LSB = 25;

  // Major opcodes, instruction bits [15:12]
  localparam logic [3:0] OPC_NOOP   = 4'h0;
  localparam logic [3:0] OPC_INPUT  = 4'h1;
  localparam logic [3:0] OPC_MOVE   = 4'h2;
  localparam logic [3:0] OPC_LOADI  = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_ADDI   = 4'h5;
  localparam logic [3:0] OPC_SUB    = 4'h6;
  localparam logic [3:0] OPC_SUBI   = 4'h7;
  localparam logic [3:0] OPC_LOAD   = 4'h8;
  localparam logic [3:0] OPC_LOADF  = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_STOREF = 4'hB;
  localparam logic [3:0] OPC_SHIFT  = 4'hC;
  localparam logic [3:0] OPC_CMP    = 4'hD;
  localparam logic [3:0] OPC_JUMP   = 4'hE;
  localparam logic [3:0] OPC_BRANCH = 4'hF;

  // One-hot bit indices within opcode bus [22:0]
  localparam int B_NOOP    = 0;
  localparam int B_INPUTC  = 1;
  localparam int B_INPUTCF = 2;
  localparam int B_INPUTD  = 3;
  localparam int B_INPUTDF = 4;
  localparam int B_MOVE    = 5;
  localparam int B_LOADI   = 6;
  localparam int B_ADD     = 7;
  localparam int B_ADDI    = 8;
  localparam int B_SUB     = 9;
  localparam int B_SUBI    = 10;
  localparam int B_LOAD    = 11;
  localparam int B_LOADF   = 12;
  localparam int B_STORE   = 13;
  localparam int B_STOREF  = 14;
  localparam int B_SHIFTL  = 15;
  localparam int B_SHIFTR  = 16;
  localparam int B_CMP     = 17;
  localparam int B_JUMP    = 18;
  localparam int B_BRE     = 19;
  localparam int B_BRNE    = 20;
  localparam int B_BRG     = 21;
  localparam int B_BRGE    = 22;

  // Fetch FSM state encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_READ = 2'd1;
  localparam fetch_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/i281_fetch_unit_if.sv
// Instruction memory port of the fetch unit.
//   imem_en    read enable (master -> memory)
//   imem_addr  word address (master -> memory)
//   imem_rdata read data, valid the cycle after imem_en (memory -> master)
interface i281_fetch_unit_if #(
  parameter int PC_W = 6
);
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;

  modport master (output imem_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/i281_opcode_decode.sv
// Combinational i281 instruction decoder.
//   instr_i  16-bit instruction
//   opbus_o  {RX, RY, one-hot opcode[22:0]}; exactly one opcode bit is set
module i281_opcode_decode
  import i281_pkg::*;
(
  input  logic [15:0]        instr_i,
  output logic [OPBUS_W-1:0] opbus_o
);

  logic [OPBUS_OP_W-1:0] op_oh;
  logic [1:0]            ry;

  assign ry = instr_i[9:8];

  always_comb begin
    op_oh = '0;
    case (instr_i[15:12])
      OPC_NOOP:   op_oh[B_NOOP]   = 1'b1;
      OPC_INPUT: begin
        case (ry)
          2'b00:   op_oh[B_INPUTC]  = 1'b1;
          2'b01:   op_oh[B_INPUTCF] = 1'b1;
          2'b10:   op_oh[B_INPUTD]  = 1'b1;
          default: op_oh[B_INPUTDF] = 1'b1;
        endcase
      end
      OPC_MOVE:   op_oh[B_MOVE]   = 1'b1;
      OPC_LOADI:  op_oh[B_LOADI]  = 1'b1;
      OPC_ADD:    op_oh[B_ADD]    = 1'b1;
      OPC_ADDI:   op_oh[B_ADDI]   = 1'b1;
      OPC_SUB:    op_oh[B_SUB]    = 1'b1;
      OPC_SUBI:   op_oh[B_SUBI]   = 1'b1;
      OPC_LOAD:   op_oh[B_LOAD]   = 1'b1;
      OPC_LOADF:  op_oh[B_LOADF]  = 1'b1;
      OPC_STORE:  op_oh[B_STORE]  = 1'b1;
      OPC_STOREF: op_oh[B_STOREF] = 1'b1;
      OPC_SHIFT: begin
        if (ry[0]) op_oh[B_SHIFTR] = 1'b1;
        else       op_oh[B_SHIFTL] = 1'b1;
      end
      OPC_CMP:    op_oh[B_CMP]    = 1'b1;
      OPC_JUMP:   op_oh[B_JUMP]   = 1'b1;
      default: begin // OPC_BRANCH
        case (ry)
          2'b00:   op_oh[B_BRE]  = 1'b1;
          2'b01:   op_oh[B_BRNE] = 1'b1;
          2'b10:   op_oh[B_BRG]  = 1'b1;
          default: op_oh[B_BRGE] = 1'b1;
        endcase
      end
    endcase
  end

  assign opbus_o = {instr_i[11:10], instr_i[9:8], op_oh};

endmodule

// File: rtl/i281_fetch_unit.sv
// i281 fetch unit: owns PC and IR, fetches from synchronous-read instruction
// memory, applies branch offsets, and drives the registered opcode bus.
//   clock, reset   system clock, async active-high reset
//   run            fetch enable (gates acceptance only)
//   fetch_req      level request, held by the control FSM until fetch_done
//   branch_take    pulse: PC <= PC + sext(IR[7:0]); only legal in IDLE
//   imem           instruction memory port (master side)
//   fetch_done     one-cycle pulse when IR/opcode_bus have been updated
//   busy           fetch in flight (READ or DONE)
//   pc, imm        current PC, IR[7:0]
//   opcode_bus     {RX, RY, one-hot opcode}
//   proto_err      sticky: branch_take seen outside IDLE
//
// state | meaning
// IDLE  | waiting for fetch_req & run; branches applied here
// READ  | memory data valid; capture IR, decode, post-increment PC
// DONE  | fetch_done high for this single cycle
module i281_fetch_unit
  import i281_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                fetch_req,
  input  logic                branch_take,
  i281_fetch_unit_if.master   imem,
  output logic                fetch_done,
  output logic                busy,
  output logic [PC_W-1:0]     pc,
  output logic [7:0]          imm,
  output logic [OPBUS_W-1:0]  opcode_bus,
  output logic                proto_err
);

  localparam logic [OPBUS_W-1:0] OPBUS_RST = OPBUS_W'(1) << B_NOOP;

  fetch_state_t          state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [OPBUS_W-1:0]    opbus_q, opbus_d, dec_opbus;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic [15:0]           br_off;

  // Decode straight off memory data so the result lands with IR
  i281_opcode_decode u_decode (
    .instr_i (imem.imem_rdata),
    .opbus_o (dec_opbus)
  );

  assign br_off = {{8{ir_q[7]}}, ir_q[7:0]};

  // branch_take wins over a simultaneous request; the fetch retries next cycle
  assign imem.imem_en   = (state_q == ST_IDLE) & fetch_req & run & ~branch_take;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opbus_d = opbus_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_take) pc_d = pc_q + br_off[PC_W-1:0];
        else if (fetch_req && run) state_d = ST_READ;
      end
      ST_READ: begin
        ir_d    = imem.imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        opbus_d = dec_opbus;
        done_d  = 1'b1;
        state_d = ST_DONE;
        if (branch_take) perr_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (branch_take) perr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      opbus_q <= OPBUS_RST;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opbus_q <= opbus_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign fetch_done = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign pc         = pc_q;
  assign imm        = ir_q[7:0];
  assign opcode_bus = opbus_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_i281_fetch_unit.sv
module tb_i281_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        fetch_req = 1'b0;
  logic        branch_take = 1'b0;
  logic        fetch_done, busy, proto_err;
  logic [5:0]  pc;
  logic [7:0]  imm;
  logic [26:0] opcode_bus;

  logic [15:0] mem [64];
  int nvec = 0;
  int nerr = 0;

  i281_fetch_unit_if #(.PC_W(6)) imem_if ();

  i281_fetch_unit #(.PC_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .fetch_req   (fetch_req),
    .branch_take (branch_take),
    .imem        (imem_if.master),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .pc          (pc),
    .imm         (imm),
    .opcode_bus  (opcode_bus),
    .proto_err   (proto_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (imem_if.imem_en) imem_if.imem_rdata <= mem[imem_if.imem_addr];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    fetch_req = 1'b0; branch_take = 1'b0; run = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  // Full fetch from IDLE, returns in IDLE after DONE
  task automatic do_fetch();
    fetch_req = 1'b1;
    tick(); tick();
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic do_branch();
    branch_take = 1'b1;
    tick();
    branch_take = 1'b0;
    #1;
  endtask

  function automatic logic [26:0] exp_opbus(logic [15:0] ins);
    int base [16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    logic [3:0]  op;
    logic [1:0]  ry;
    logic [22:0] oh;
    int idx;
    op = ins[15:12];
    ry = ins[9:8];
    idx = base[op];
    if (op == 4'h1 || op == 4'hF) idx = idx + int'(ry);
    if (op == 4'hC) idx = idx + int'(ry[0]);
    oh = '0;
    oh[idx] = 1'b1;
    return {ins[11:10], ins[9:8], oh};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    nvec++; if (pc !== 6'd0) begin nerr++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    nvec++; if (opcode_bus !== 27'h0000001) begin nerr++; $display("FAIL reset_opbus got=%h exp=0000001", opcode_bus); end
    nvec++; if (imm !== 8'h00) begin nerr++; $display("FAIL reset_imm got=%h exp=00", imm); end
    nvec++; if ({fetch_done, busy, imem_if.imem_en, proto_err} !== 4'b0000) begin
      nerr++; $display("FAIL reset_flags got=%b exp=0000", {fetch_done, busy, imem_if.imem_en, proto_err});
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_fetch();
    do_reset();
    mem[0] = 16'h4600;
    fetch_req = 1'b1;
    #1;
    nvec++; if (imem_if.imem_en !== 1'b1 || imem_if.imem_addr !== 6'd0) begin
      nerr++; $display("FAIL fetch_accept got en=%b addr=%0d exp en=1 addr=0", imem_if.imem_en, imem_if.imem_addr);
    end
    tick();
    nvec++; if (busy !== 1'b1 || fetch_done !== 1'b0) begin
      nerr++; $display("FAIL fetch_t1 got busy=%b done=%b exp busy=1 done=0", busy, fetch_done);
    end
    tick();
    fetch_req = 1'b0;
    nvec++; if (fetch_done !== 1'b1) begin nerr++; $display("FAIL fetch_done_t2 got=%b exp=1", fetch_done); end
    nvec++; if (opcode_bus !== 27'h3000080) begin nerr++; $display("FAIL fetch_opbus got=%h exp=3000080", opcode_bus); end
    nvec++; if (pc !== 6'd1) begin nerr++; $display("FAIL fetch_pc got=%0d exp=1", pc); end
    tick();
    nvec++; if (fetch_done !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL fetch_end got done=%b busy=%b exp 0 0", fetch_done, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem[0] = 16'h003E;
    do_fetch();
    do_branch();
    nvec++; if (pc !== 6'd63) begin nerr++; $display("FAIL wrap_setup_pc got=%0d exp=63", pc); end
    mem[63] = 16'hF300;
    do_fetch();
    nvec++; if (opcode_bus !== 27'h1C00000) begin nerr++; $display("FAIL wrap_opbus got=%h exp=1C00000", opcode_bus); end
    nvec++; if (pc !== 6'd0) begin nerr++; $display("FAIL wrap_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_branch();
    do_reset();
    mem[0] = 16'h0008;
    do_fetch();
    do_branch();
    mem[9] = 16'h00FC;
    do_fetch();
    nvec++; if (pc !== 6'd10 || imm !== 8'hFC) begin
      nerr++; $display("FAIL branch_setup got pc=%0d imm=%h exp pc=10 imm=fc", pc, imm);
    end
    do_branch();
    nvec++; if (pc !== 6'd6) begin nerr++; $display("FAIL branch_neg got=%0d exp=6", pc); end
    mem[6] = 16'h0002;
    do_fetch();
    do_branch();
    mem[9] = 16'h0005;
    do_fetch();
    do_branch();
    nvec++; if (pc !== 6'd15) begin nerr++; $display("FAIL branch_pos got=%0d exp=15", pc); end
  endtask

  task automatic test_branch_fetch();
    do_reset();
    mem[0] = 16'h0003;
    do_fetch();
    do_branch();
    mem[4] = 16'h0002;
    do_fetch();
    mem[7] = 16'h5123;
    branch_take = 1'b1;
    fetch_req = 1'b1;
    #1;
    nvec++; if (imem_if.imem_en !== 1'b0) begin nerr++; $display("FAIL bf_defer_en got=%b exp=0", imem_if.imem_en); end
    tick();
    branch_take = 1'b0;
    #1;
    nvec++; if (pc !== 6'd7) begin nerr++; $display("FAIL bf_pc got=%0d exp=7", pc); end
    nvec++; if (imem_if.imem_en !== 1'b1 || imem_if.imem_addr !== 6'd7) begin
      nerr++; $display("FAIL bf_fetch got en=%b addr=%0d exp en=1 addr=7", imem_if.imem_en, imem_if.imem_addr);
    end
    tick();
    branch_take = 1'b1;
    tick();
    branch_take = 1'b0;
    fetch_req = 1'b0;
    nvec++; if (fetch_done !== 1'b1 || opcode_bus !== 27'h0800100) begin
      nerr++; $display("FAIL bf_result got done=%b opbus=%h exp done=1 opbus=0800100", fetch_done, opcode_bus);
    end
    nvec++; if (pc !== 6'd8) begin nerr++; $display("FAIL bf_read_branch_pc got=%0d exp=8", pc); end
    nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL bf_proto_err got=%b exp=1", proto_err); end
    tick(); tick();
    nvec++; if (proto_err !== 1'b1 || pc !== 6'd8) begin
      nerr++; $display("FAIL bf_sticky got err=%b pc=%0d exp err=1 pc=8", proto_err, pc);
    end
  endtask

  task automatic test_run_gate();
    do_reset();
    mem[0] = 16'h8D00;
    run = 1'b0;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (imem_if.imem_en !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL run_gate[%0d] got en=%b busy=%b exp 0 0", i, imem_if.imem_en, busy);
      end
    end
    run = 1'b1;
    #1;
    nvec++; if (imem_if.imem_en !== 1'b1 || imem_if.imem_addr !== 6'd0) begin
      nerr++; $display("FAIL run_accept got en=%b addr=%0d exp en=1 addr=0", imem_if.imem_en, imem_if.imem_addr);
    end
    tick();
    run = 1'b0;
    tick();
    fetch_req = 1'b0;
    nvec++; if (fetch_done !== 1'b1 || opcode_bus !== 27'h6800800 || pc !== 6'd1) begin
      nerr++; $display("FAIL run_drop_complete got done=%b opbus=%h pc=%0d exp done=1 opbus=6800800 pc=1",
                       fetch_done, opcode_bus, pc);
    end
    tick();
    run = 1'b1;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    mem[0] = 16'h2000;
    fetch_req = 1'b1;
    tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_in_read got busy=%b exp=1", busy); end
    #2;
    reset = 1'b1;
    fetch_req = 1'b0;
    #1;
    nvec++; if (pc !== 6'd0 || opcode_bus !== 27'h0000001) begin
      nerr++; $display("FAIL rmid_values got pc=%0d opbus=%h exp pc=0 opbus=0000001", pc, opcode_bus);
    end
    nvec++; if (fetch_done !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      nerr++; $display("FAIL rmid_flags got done=%b busy=%b err=%b exp 0 0 0", fetch_done, busy, proto_err);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) reset = 1'b0;
      if (fetch_done === 1'b1) pulses++;
    end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL rmid_no_done got pulses=%0d exp=0", pulses); end
    nvec++; if (pc !== 6'd0) begin nerr++; $display("FAIL rmid_pc_after got=%0d exp=0", pc); end
  endtask

  task automatic test_decode_sweep();
    logic [5:0]  a;
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      mem[i] = {a[5:2], a[1:0] ^ 2'b10, a[1:0], 2'b00, a};
    end
    for (int i = 0; i < 64; i++) begin
      ins = mem[i];
      do_fetch();
      nvec++; if (opcode_bus !== exp_opbus(ins)) begin
        nerr++; $display("FAIL sweep_opbus[%0d] got=%h exp=%h", i, opcode_bus, exp_opbus(ins));
      end
      nvec++; if (!$onehot(opcode_bus[22:0])) begin
        nerr++; $display("FAIL sweep_onehot[%0d] got=%h exp=one bit", i, opcode_bus[22:0]);
      end
      nvec++; if (pc !== 6'(i + 1) || imm !== ins[7:0]) begin
        nerr++; $display("FAIL sweep_pc_imm[%0d] got pc=%0d imm=%h exp pc=%0d imm=%h", i, pc, imm, 6'(i + 1), ins[7:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_fetch();
    test_wrap();
    test_branch();
    test_branch_fetch();
    test_reset_mid();
    test_run_gate();
    test_decode_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i281_fetch_unit.md
Name: i281_fetch_unit

Overview:
- Upstream neighbour of the multicycle control FSM. Owns the program counter (PC) and the instruction register (IR).
- Fetches 16-bit instructions from a synchronous-read instruction memory and applies jump/branch targets.
- Drives the registered 27-bit opcode bus that the control FSM consumes. The bus carries a 23-bit one-hot opcode plus the RX/RY fields.
- Also exports the IR immediate byte to the datapath.

Parameters:
- PC_W, 6, PC and instruction-memory address width (64 words).
- INSTR_W, 16, instruction width; fixed, not to be overridden.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  fetch enable; when 0, no new fetch is accepted
- fetch_req  input  1  level request from FSM IF state; held until fetch_done
- branch_take  input  1  one-cycle pulse: PC <= PC + sext(IR[7:0])
- imem_en  output  1  instruction memory read enable
- imem_addr  output  PC_W  instruction memory address
- imem_rdata  input  16  read data, valid the cycle after imem_en
- fetch_done  output  1  one-cycle pulse: IR/opcode_bus updated
- busy  output  1  fetch in flight
- pc  output  PC_W  current PC
- imm  output  8  IR[7:0]
- opcode_bus  output  27  [22:0] one-hot opcode, [24:23]=RY, [26:25]=RX
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async) values:
  - PC=0, IR=16'h0000, opcode_bus=27'h0000001 (NOOP).
  - fetch_done=0, busy=0, imem_en=0, proto_err=0, state=IDLE.
- States: IDLE, READ, DONE.
- IDLE:
  - If fetch_req & run & !branch_take: imem_en=1 and imem_addr=PC (combinational), then go to READ.
  - Otherwise stay in IDLE and keep imem_en=0.
- READ (imem_rdata valid):
  - IR<=imem_rdata.
  - PC<=PC+1, mod 2^PC_W; 63 wraps to 0.
  - opcode_bus<=decode(imem_rdata).
  - fetch_done<=1; go to DONE.
- DONE:
  - fetch_done=1 for exactly this cycle; go to IDLE.
  - fetch_req still high in DONE is not a new request. The FSM drops it on fetch_done. A new fetch needs fetch_req high in IDLE.
- Latency: request accepted in cycle T; IR valid and fetch_done high in T+2.
- busy=1 in READ and DONE.
- branch_take:
  - Honoured only in IDLE: PC <= PC + sign-extended IR[7:0], truncated to PC_W bits.
  - PC is already post-incremented, so the target is (fetch address + 1 + offset).
  - branch_take together with fetch_req in IDLE: the branch is applied and the fetch is deferred to the next cycle.
  - branch_take in READ/DONE: ignored; proto_err<=1, sticky until reset.
- run dropped mid-fetch: the in-flight fetch completes normally. run only gates acceptance.
- Reset mid-fetch: immediate return to the reset values; the pending memory data is discarded.
- Decode:
  - RX=IR[11:10], RY=IR[9:8]. The opcode is taken from IR[15:12]; sub-opcodes use the RY field.
  - 0000 -> bit0 NOOP.
  - 0001 -> by RY 00/01/10/11: bit1 INPUTC, bit2 INPUTCF, bit3 INPUTD, bit4 INPUTDF.
  - 0010 -> bit5 MOVE; 0011 -> bit6 LOADI/LOADP.
  - 0100 -> bit7 ADD; 0101 -> bit8 ADDI; 0110 -> bit9 SUB; 0111 -> bit10 SUBI.
  - 1000 -> bit11 LOAD; 1001 -> bit12 LOADF; 1010 -> bit13 STORE; 1011 -> bit14 STOREF.
  - 1100 -> RY[0]=0 bit15 SHIFTL, RY[0]=1 bit16 SHIFTR.
  - 1101 -> bit17 CMP; 1110 -> bit18 JUMP.
  - 1111 -> by RY 00/01/10/11: bit19 BRE, bit20 BRNE, bit21 BRG, bit22 BRGE.
- Exactly one bit of opcode_bus[22:0] is set at all times.

Decomposition:
- Shared package i281_pkg holds:
  - 4-bit major opcode constants.
  - one-hot bit-index constants 0..22 (NOOP..BRGE).
  - OPBUS_W=27 and field positions.
  - fetch state typedef.
- These constants are also used by the control FSM rewrite.
- One sub-module, i281_opcode_decode: purely combinational, 16-bit instruction -> 27-bit opcode bus. It is instantiated on imem_rdata so its output is registered into opcode_bus.

Test Plan:
- Reset mid-READ -> PC=0, opcode_bus=27'h0000001, fetch_done never pulses.
- Fetch with memory[0]=16'h4600 (ADD RX=1,RY=2), fetch_req at T -> imem_en/imem_addr=0 at T; at T+2 fetch_done=1, opcode_bus[7]=1, [26:25]=01, [24:23]=10, pc=1.
- PC=63 with memory[63]=16'hF300 (BRGE) -> opcode_bus[22]=1, pc wraps to 0.
- IR imm=8'hFC, PC=10, branch_take in IDLE -> pc=6. With imm=8'h05 -> pc=15.
- branch_take and fetch_req together in IDLE with PC=5, imm=2 -> pc=7, then fetch from address 7 (imem_en one cycle later). branch_take during READ -> pc unchanged, proto_err=1 until reset.
- run=0 with fetch_req held -> imem_en stays 0, busy=0; raise run -> fetch proceeds with 2-cycle latency. Sweep all 16 opcodes × RY values -> exactly one hot bit, matching the decode map.
